// File: rtl/execute_stage_pipe_pkg.sv
// Shared opcode, branch-condition and FSM encodings for the execute stage.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_ROL   = 4'd8,
        OP_SEQ   = 4'd9,
        OP_SLT   = 4'd10,
        OP_SLE   = 4'd11,
        OP_SCO   = 4'd12,
        OP_MUL   = 4'd13,
        OP_PASSB = 4'd14,
        OP_RSVD  = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQZ  = 3'd1,
        BR_NEZ  = 3'd2,
        BR_LTZ  = 3'd3,
        BR_GEZ  = 3'd4,
        BR_JUMP = 3'd5,
        BR_JREG = 3'd6,
        BR_RSVD = 3'd7
    } br_cond_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/execute_stage_pipe_mul_iter.sv
// Iterative shift-add multiplier: bit 0 is folded in on the start edge, one more bit per
// cycle after that; done holds (count saturated) until the parent clears it.
module mul_iter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] prod
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            busy   <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CNT_W'(1);
            prod   <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
        end else if (busy && cnt != LAST) begin
            prod   <= prod + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign done = busy && (cnt == LAST);

endmodule

// File: rtl/execute_stage_pipe.sv
// Pipelined execute stage: ALU, branch resolution and iterative multiply feeding a
// registered EX/MEM slot with valid/ready handshakes on both sides.
module execute_stage_pipe
    import exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] pc_inc,
    input  logic [3:0]        alu_op,
    input  logic [2:0]        br_cond,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              ofl,
    output logic [DATA_W-1:0] pc_next,
    output logic              br_taken,
    output logic              err
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    state_e   state, state_n;
    alu_op_e  op;
    br_cond_e cond;

    assign op   = alu_op_e'(alu_op);
    assign cond = br_cond_e'(br_cond);

    logic [SH_W-1:0]     sh;
    logic [DATA_W:0]     sum_c;
    logic [DATA_W-1:0]   sum, neg_b, diff;
    logic [2*DATA_W-1:0] rol_w;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_ofl;

    assign sh    = op_b[SH_W-1:0];
    assign sum_c = {1'b0, op_a} + {1'b0, op_b};
    assign sum   = sum_c[DATA_W-1:0];
    assign neg_b = ~op_b + DATA_W'(1);
    assign diff  = op_a + neg_b;
    assign rol_w = {op_a, op_a} << sh;

    // MUL and the reserved opcode fall through to a zero result.
    always_comb begin
        alu_res = '0;
        alu_ofl = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ofl = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ofl = (op_a[MSB] == neg_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SLL:   alu_res = op_a << sh;
            OP_SRL:   alu_res = op_a >> sh;
            OP_SRA:   alu_res = DATA_W'($signed(op_a) >>> sh);
            OP_ROL:   alu_res = rol_w[2*DATA_W-1:DATA_W];
            OP_SEQ:   alu_res[0] = (op_a == op_b);
            OP_SLT:   alu_res[0] = ($signed(op_a) < $signed(op_b));
            OP_SLE:   alu_res[0] = ($signed(op_a) <= $signed(op_b));
            OP_SCO:   alu_res[0] = sum_c[DATA_W];
            OP_PASSB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    logic              is_mul, op_err, err_c, cond_hit, take;
    logic [DATA_W-1:0] target, pc_sel;

    assign is_mul = (op == OP_MUL) && MUL_EN;
    assign op_err = (op == OP_RSVD) || ((op == OP_MUL) && !MUL_EN);
    assign err_c  = op_err || (cond == BR_RSVD);

    always_comb begin
        cond_hit = 1'b0;
        case (cond)
            BR_EQZ:          cond_hit = (op_a == '0);
            BR_NEZ:          cond_hit = (op_a != '0);
            BR_LTZ:          cond_hit = op_a[MSB];
            BR_GEZ:          cond_hit = ~op_a[MSB];
            BR_JUMP, BR_JREG: cond_hit = 1'b1;
            default:         cond_hit = 1'b0;
        endcase
    end

    // Targets wrap modulo 2^DATA_W; any decode error suppresses the transfer.
    assign target = ((cond == BR_JREG) ? op_a : pc_inc) + imm;
    assign take   = cond_hit && !err_c;
    assign pc_sel = take ? target : pc_inc;

    logic              xfer, start_mul, load_alu, load_mul, slot_free;
    logic              mul_busy, mul_done;
    logic [DATA_W-1:0] mul_prod;

    always_comb begin
        slot_free = ~out_valid | out_ready;
        in_ready  = (state == IDLE) & ~flush & slot_free;
        xfer      = in_valid & in_ready;
        start_mul = xfer & is_mul;
        load_alu  = xfer & ~is_mul;
        load_mul  = (state == MUL) & mul_busy & mul_done & ~flush & slot_free;
        state_n   = state;
        case (state)
            IDLE:    if (start_mul) state_n = MUL;
            MUL:     if (flush || load_mul) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (start_mul),
        .clear (flush | load_mul),
        .a     (op_a),
        .b     (op_b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Branch fields of a multiply are resolved at transfer and ride alongside the product.
    logic [DATA_W-1:0] pend_pc;
    logic              pend_taken, pend_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_pc    <= '0;
            pend_taken <= 1'b0;
            pend_err   <= 1'b0;
        end else if (start_mul) begin
            pend_pc    <= pc_sel;
            pend_taken <= take;
            pend_err   <= err_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            ofl       <= 1'b0;
            pc_next   <= '0;
            br_taken  <= 1'b0;
            err       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_alu) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            ofl       <= alu_ofl;
            pc_next   <= pc_sel;
            br_taken  <= take;
            err       <= err_c;
        end else if (load_mul) begin
            out_valid <= 1'b1;
            result    <= mul_prod;
            ofl       <= 1'b0;
            pc_next   <= pend_pc;
            br_taken  <= pend_taken;
            err       <= pend_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
